rans_byte_reverser: RTL

Downstream stage of the rANS encoder top. It collects the encoded byte stream (`valid`/`enc`) for one block into a LIFO buffer. On `flush_i` it replays the buffered bytes in reverse order over a valid/ready stream, because rANS emits bytes in the reverse of decode order. The decoder and DMA side consume its output directly.

---
 rtl/rans_byte_reverser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rans_byte_reverser.sv
// ============================================================================
//  Module   : rans_byte_reverser
//  Purpose  : LIFO block buffer that replays rANS encoder bytes in reverse
//             order over a valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rans_byte_reverser #(
    parameter int DEPTH = 1024,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [7:0]    enc_i,
    input  logic          flush_i,
    output logic          m_valid_o,
    output logic [7:0]    m_data_o,
    output logic          m_last_o,
    input  logic          m_ready_i,
    output logic          busy_o,
    output logic [CW-1:0] count_o,
    output logic          err_o
);

    localparam int c_AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   w_ptr_d;
    logic [c_AW-1:0] r_raddr;
    logic [c_AW-1:0] w_raddr_d;
    logic            r_m_valid;
    logic            w_m_valid_d;
    logic [7:0]      r_m_data;
    logic            r_m_last;
    logic            w_m_last_d;
    logic            r_busy;
    logic            r_err;
    logic            w_err_d;

    logic            w_ram_we;
    logic            w_ram_re;
    logic            w_bypass;
    logic            w_out_ld;
    logic [c_AW-1:0] w_ram_addr;
    logic            w_full;
    logic            w_wr_ok;

    logic [7:0]      r_mem [DEPTH];
    logic [7:0]      r_rd_q;

    assign w_full  = (r_ptr >= CW'(DEPTH));
    assign w_wr_ok = valid_i && !w_full;

    always_comb begin
        w_state_d   = r_state;
        w_ptr_d     = r_ptr;
        w_raddr_d   = r_raddr;
        w_m_valid_d = r_m_valid;
        w_m_last_d  = r_m_last;
        w_err_d     = r_err;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_bypass    = 1'b0;
        w_out_ld    = 1'b0;
        w_ram_addr  = r_ptr[c_AW-1:0];

        unique case (r_state)
            S_FILL: begin
                if (w_wr_ok) begin
                    w_ram_we = 1'b1;
                    w_ptr_d  = r_ptr + CW'(1);
                end
                if (valid_i && w_full) begin
                    w_err_d = 1'b1;
                end
                if (flush_i && (w_ptr_d != '0)) begin
                    w_state_d = S_LOAD;
                    w_raddr_d = c_AW'(w_ptr_d - CW'(2));
                    // The port is busy writing the newest byte, so it is
                    // forwarded straight into the read register instead.
                    if (w_wr_ok) begin
                        w_bypass = 1'b1;
                    end else begin
                        w_ram_re   = 1'b1;
                        w_ram_addr = c_AW'(w_ptr_d - CW'(1));
                    end
                end
            end

            S_LOAD: begin
                if (valid_i) begin
                    w_err_d = 1'b1;
                end
                w_out_ld    = 1'b1;
                w_m_valid_d = 1'b1;
                w_m_last_d  = (r_ptr == CW'(1));
                w_ram_re    = 1'b1;
                w_ram_addr  = r_raddr;
                w_raddr_d   = r_raddr - c_AW'(1);
                w_state_d   = S_DRAIN;
            end

            S_DRAIN: begin
                if (valid_i) begin
                    w_err_d = 1'b1;
                end
                if (m_ready_i) begin
                    w_ptr_d = r_ptr - CW'(1);
                    if (r_ptr == CW'(1)) begin
                        w_m_valid_d = 1'b0;
                        w_m_last_d  = 1'b0;
                        w_state_d   = S_FILL;
                    end else begin
                        w_out_ld   = 1'b1;
                        w_m_last_d = (r_ptr == CW'(2));
                        w_ram_re   = 1'b1;
                        w_ram_addr = r_raddr;
                        w_raddr_d  = r_raddr - c_AW'(1);
                    end
                end
            end

            default: begin
                w_state_d = S_FILL;
            end
        endcase
    end

    // Storage is left unreset; the pointer alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= enc_i;
        end
        if (w_bypass) begin
            r_rd_q <= enc_i;
        end else if (w_ram_re) begin
            r_rd_q <= r_mem[w_ram_addr];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_FILL;
            r_ptr     <= '0;
            r_raddr   <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= 8'h00;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_ptr     <= w_ptr_d;
            r_raddr   <= w_raddr_d;
            r_m_valid <= w_m_valid_d;
            r_m_last  <= w_m_last_d;
            r_busy    <= (w_state_d != S_FILL);
            r_err     <= w_err_d;
            if (w_out_ld) begin
                r_m_data <= r_rd_q;
            end
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_m_data;
    assign m_last_o  = r_m_last;
    assign busy_o    = r_busy;
    assign count_o   = r_ptr;
    assign err_o     = r_err;

endmodule

`default_nettype wire
